// File: rtl/pipe_pkg.sv
// Shared definitions for every inter-stage pipeline register instance:
// occupancy state encoding and default field widths.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_KEEP_W = 32;
    localparam int DEF_WA_W   = 5;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async active-high reset.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, and a flush that zeroes the payload but still loads the sideband.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEEP_W = DEF_KEEP_W,
    parameter int WA_W   = DEF_WA_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [WA_W-1:0]   in_wa,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [WA_W-1:0]   out_wa,
    output logic [KEEP_W-1:0] out_keep,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits for ready, and flush overrides both sides.
    logic [1:0]        state;
    logic [DATA_W-1:0] head_data;
    logic [WA_W-1:0]   head_wa;
    logic [KEEP_W-1:0] head_keep;
    logic              acc;
    logic              rel;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = head_data;
    assign out_wa    = head_wa;
    assign out_keep  = head_keep;
    assign dbg_state = state;

    assign acc = in_valid && in_ready;
    assign rel = out_valid && out_ready;

    // Only flushes that actually throw away a held entry are counted.
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush && out_valid),
        .count (flush_cnt)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_data;
            logic [WA_W-1:0]   skid_wa;
            logic [KEEP_W-1:0] skid_keep;
            logic              ready_q;

            // Registered ready: drops only once both slots are occupied.
            assign in_ready = ready_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state     <= ST_EMPTY;
                    head_data <= '0;
                    head_wa   <= '0;
                    head_keep <= '0;
                    skid_data <= '0;
                    skid_wa   <= '0;
                    skid_keep <= '0;
                    ready_q   <= 1'b1;
                end else if (flush) begin
                    state     <= ST_EMPTY;
                    head_data <= '0;
                    head_wa   <= '0;
                    head_keep <= in_keep;
                    skid_data <= '0;
                    skid_wa   <= '0;
                    skid_keep <= '0;
                    ready_q   <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (acc) begin
                                head_data <= in_data;
                                head_wa   <= in_wa;
                                head_keep <= in_keep;
                                state     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (acc && !rel) begin
                                skid_data <= in_data;
                                skid_wa   <= in_wa;
                                skid_keep <= in_keep;
                                state     <= ST_TWO;
                                ready_q   <= 1'b0;
                            end else if (acc && rel) begin
                                head_data <= in_data;
                                head_wa   <= in_wa;
                                head_keep <= in_keep;
                            end else if (rel) begin
                                head_data <= '0;
                                head_wa   <= '0;
                                head_keep <= '0;
                                state     <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (rel) begin
                                head_data <= skid_data;
                                head_wa   <= skid_wa;
                                head_keep <= skid_keep;
                                skid_data <= '0;
                                skid_wa   <= '0;
                                skid_keep <= '0;
                                state     <= ST_ONE;
                                ready_q   <= 1'b1;
                            end
                        end
                        default: begin
                            state   <= ST_EMPTY;
                            ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_comb
            // Single slot: can take a new entry whenever the head leaves this cycle.
            assign in_ready = !out_valid || out_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state     <= ST_EMPTY;
                    head_data <= '0;
                    head_wa   <= '0;
                    head_keep <= '0;
                end else if (flush) begin
                    state     <= ST_EMPTY;
                    head_data <= '0;
                    head_wa   <= '0;
                    head_keep <= in_keep;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (acc) begin
                                head_data <= in_data;
                                head_wa   <= in_wa;
                                head_keep <= in_keep;
                                state     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (acc) begin
                                head_data <= in_data;
                                head_wa   <= in_wa;
                                head_keep <= in_keep;
                            end else if (rel) begin
                                head_data <= '0;
                                head_wa   <= '0;
                                head_keep <= '0;
                                state     <= ST_EMPTY;
                            end
                        end
                        default: begin
                            state <= ST_EMPTY;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed MEM/WB stage register: a generic inter-stage pipeline register with a valid/ready handshake, an optional 2-entry skid buffer, and flush that clears the payload while preserving a sideband "keep" field (e.g. PC+8 for EPC).
- Instantiated between any two pipeline stages (F/D, D/E, E/M, M/W).
- Adds backpressure, bubble tracking and a flush-discard counter.

Parameters:
- DATA_W, 64: width of the payload cleared on flush (aluout, dm, instr, ...).
- KEEP_W, 32: width of the sideband loaded even on flush (PC+8).
- WA_W, 5: width of the register-file write address; zeroed on flush.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready.
- CNT_W, 16: width of the flush-discard counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_wa  in  WA_W  upstream write address.
- in_keep  in  KEEP_W  upstream sideband.
- flush  in  1  discard all held entries (exception/ERET).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- out_wa  out  WA_W  head write address.
- out_keep  out  KEEP_W  head sideband.
- flush_cnt  out  CNT_W  saturating count of flushes that discarded ≥1 valid entry.

Behaviour:
- Reset (async, rst=1): state EMPTY; out_valid=0; out_data, out_wa, out_keep, skid regs = 0; flush_cnt=0; in_ready=1. No transfers are recorded while rst=1.
- Accept: in_valid && in_ready at a rising edge. Release: out_valid && out_ready at a rising edge.
- Head register drives out_*. Data entering an EMPTY stage appears on out_* one cycle later (latency 1).
- SKID=1 states:
  - EMPTY: accept → ONE.
  - ONE: accept with no release → TWO (entry goes to skid); release with no accept → EMPTY; both → ONE (head loads input).
  - TWO: release → ONE (head loads skid). Accept is impossible because in_ready=0.
  - in_ready is registered: 1 in EMPTY/ONE, 0 in TWO. Neither in_ready nor out_valid depends combinationally on out_ready.
- SKID=0 states:
  - EMPTY/ONE only; no skid register is generated.
  - in_ready = !out_valid || out_ready (combinational).
  - Release and accept in the same cycle → head loads input; full throughput.
- Flush:
  - Highest priority over accept and release.
  - Next state EMPTY; out_valid=0; out_data=0; out_wa=0; skid cleared.
  - out_keep <= in_keep unconditionally, even if in_valid=0.
  - Any input offered in the flush cycle is dropped, not accepted. In SKID=0, in_ready still reads 1, but the entry is discarded.
  - in_ready=1 the cycle after a flush.
  - flush_cnt increments by 1 if the state was ONE or TWO before the flush. It saturates at 2^CNT_W-1 and never wraps.
  - Flush in EMPTY has no effect on the counter.
- out_data, out_wa and out_keep hold their values while out_valid=1 and out_ready=0 (stable under stall).
- out_wa=0 whenever out_valid=0 after a release leaves the stage EMPTY. The head is zeroed on the transition to EMPTY, so a bubble never writes the register file.
- Reset asserted mid-operation (TWO with stall) discards everything immediately and asynchronously.
- Ordering: entries exit strictly in arrival order; no duplication or loss except on flush.

Decomposition:
- Shared package pipe_pkg: state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2) and the default widths (DATA_W/KEEP_W/WA_W constants) for reuse by all stage instances.
- One natural sub-module: sat_counter (CNT_W wide, inc + sync saturation, async rst) for flush_cnt.
- The skid path is a generate block keyed on SKID, not a separate module.

Test Plan:
- Reset: assert rst mid-cycle while in TWO → out_valid=0, out_wa=0, flush_cnt=0, in_ready=1 immediately (before next clk edge).
- Streaming (SKID=1): in_valid=1 with data 1,2,3,4 and out_ready=1 always → out_data 1,2,3,4 on consecutive cycles, starting one cycle after the first accept; in_ready stays 1.
- Backpressure (SKID=1): out_ready=0 and push A,B → state TWO, in_ready=0 on the cycle after B; C is held upstream; release out_ready → outputs A,B,C in order with no loss.
- Flush in TWO: in_keep=0x0040_0010, flush=1 → next cycle out_valid=0, out_data=0, out_wa=0, out_keep=0x0040_0010, flush_cnt=1; input offered that cycle is not seen later.
- Flush while EMPTY: flush=1 → flush_cnt unchanged; out_keep loads in_keep.
- Saturation, CNT_W=2: 5 flushes each with a valid entry held → flush_cnt reads 1,2,3,3,3.
- SKID=0: out_ready toggles 1,0,1 → in_ready follows `!out_valid || out_ready` in the same cycle; throughput is 1 entry per cycle when out_ready=1.
